// File: rtl/dt_param.sv
// dt_param: two-pass chamfer distance transform, city-block or chessboard.
// Ports: clk/reset, start/mode/busy/done, source ROM sti_*, result RAM res_*.
module dt_param #(
  parameter  int IMG_W  = 128,
  parameter  int IMG_H  = 128,
  parameter  int WORD_W = 16,
  parameter  int DIST_W = 8,
  localparam int SA_W   = $clog2(IMG_W*IMG_H/WORD_W),
  localparam int RA_W   = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              sti_rd,
  output logic [SA_W-1:0]   sti_addr,
  input  logic [WORD_W-1:0] sti_di,
  output logic              res_rd,
  output logic              res_wr,
  output logic [RA_W-1:0]   res_addr,
  output logic [DIST_W-1:0] res_do,
  input  logic [DIST_W-1:0] res_di
);

  localparam int CW = $clog2(IMG_W);
  localparam int WB = $clog2(WORD_W);
  localparam int RW = RA_W - CW;

  localparam logic [RW-1:0]     ROW_L = RW'(IMG_H - 1);
  localparam logic [CW-1:0]     COL_L = CW'(IMG_W - 1);
  localparam logic [CW-1:0]     WMASK = CW'(WORD_W - 1);
  localparam logic [RA_W-1:0]   A_LAST = RA_W'(IMG_W*IMG_H - 1);
  localparam logic [RA_W-1:0]   A_ONE = RA_W'(1);
  localparam logic [RA_W-1:0]   A_ROW = RA_W'(IMG_W);
  localparam logic [DIST_W-1:0] MAXV = '1;

  typedef enum logic [3:0] {
    IDLE, F_EDGE, F_LOAD, F_RD, F_WR,
    B_EDGE, B_RD, B_WR, DONE
  } state_t;

  function automatic logic f_border(input logic [RA_W-1:0] a);
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    row = a[RA_W-1:CW];
    col = a[CW-1:0];
    return (row == '0) || (row == ROW_L) ||
           (col == '0) || (col == COL_L);
  endfunction

  // A new source word is due at every word boundary of an interior
  // row, including column 0 when a word spans the whole row.
  function automatic state_t f_enter_f(input logic [RA_W-1:0] a);
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    state_t s;
    row = a[RA_W-1:CW];
    col = a[CW-1:0];
    if (row != '0 && row != ROW_L && (col & WMASK) == '0)
      s = F_LOAD;
    else if (f_border(a))
      s = F_EDGE;
    else
      s = F_RD;
    return s;
  endfunction

  function automatic state_t f_enter_b(input logic [RA_W-1:0] a);
    return f_border(a) ? B_EDGE : B_RD;
  endfunction

  function automatic logic [DIST_W-1:0] f_min(
    input logic [DIST_W-1:0] a,
    input logic [DIST_W-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DIST_W-1:0] f_inc(input logic [DIST_W-1:0] a);
    return (a == MAXV) ? MAXV : a + DIST_W'(1);
  endfunction

  state_t            r_state, w_state, w_bstate;
  logic [RA_W-1:0]   r_addr, w_addr, w_baddr;
  logic [2:0]        r_k, w_k;
  logic              r_mode, r_ld_d;
  logic [WORD_W-1:0] r_word, w_word;
  logic [DIST_W-1:0] r_min, r_v, r_last;
  logic [DIST_W-1:0] w_nmin, w_fres, w_bres;

  logic              w_busy, w_done, w_sti_rd, w_res_rd, w_res_wr;
  logic [SA_W-1:0]   w_sti_addr;
  logic [RA_W-1:0]   w_res_addr;
  logic [DIST_W-1:0] w_res_do;

  // West/east neighbour is the pixel just finished, kept in r_last.
  always_comb begin
    w_word = r_ld_d ? sti_di : r_word;
    w_nmin = f_min(r_min, r_last);
    if (r_mode) w_nmin = f_min(w_nmin, res_di);
    w_fres = w_word[WORD_W-1] ? f_inc(w_nmin) : '0;
    w_bres = (r_v == '0) ? '0 : f_min(r_v, f_inc(w_nmin));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_state;
      r_addr  <= w_addr;
      r_k     <= w_k;
    end
  end

  always_comb begin
    w_bstate = DONE;
    w_baddr  = r_addr;
    if (r_addr != '0) begin
      w_baddr  = r_addr - A_ONE;
      w_bstate = f_enter_b(w_baddr);
    end
    w_state = r_state;
    w_addr  = r_addr;
    w_k     = r_k;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_addr  = '0;
          w_k     = '0;
          w_state = f_enter_f('0);
        end
      end
      F_LOAD: w_state = f_border(r_addr) ? F_EDGE : F_RD;
      F_EDGE, F_WR: begin
        w_k = '0;
        if (r_addr == A_LAST) begin
          w_state = f_enter_b(r_addr);
        end else begin
          w_addr  = r_addr + A_ONE;
          w_state = f_enter_f(w_addr);
        end
      end
      F_RD: begin
        if (r_k == 3'd3) w_state = F_WR;
        else             w_k = r_k + 3'd1;
      end
      B_RD: begin
        if (r_k == 3'd4) begin
          w_k = '0;
          if (w_bres != r_v) begin
            w_state = B_WR;
          end else begin
            w_state = w_bstate;
            w_addr  = w_baddr;
          end
        end else begin
          w_k = r_k + 3'd1;
        end
      end
      B_EDGE, B_WR: begin
        w_k     = '0;
        w_state = w_bstate;
        w_addr  = w_baddr;
      end
      DONE:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered, then registered.
  always_comb begin
    w_busy     = (w_state != IDLE) && (w_state != DONE);
    w_done     = (w_state == DONE);
    w_sti_rd   = (w_state == F_LOAD);
    w_sti_addr = SA_W'(w_addr >> WB);
    w_res_rd   = 1'b0;
    w_res_wr   = 1'b0;
    w_res_addr = w_addr;
    w_res_do   = '0;
    unique case (w_state)
      F_EDGE: w_res_wr = 1'b1;
      F_WR: begin
        w_res_wr = 1'b1;
        w_res_do = w_fres;
      end
      B_WR: begin
        w_res_wr = 1'b1;
        w_res_do = w_bres;
      end
      F_RD: begin
        w_res_rd = (w_k != 3'd3);
        case (w_k)
          3'd0:    w_res_addr = w_addr - A_ROW - A_ONE;
          3'd1:    w_res_addr = w_addr - A_ROW;
          3'd2:    w_res_addr = w_addr - A_ROW + A_ONE;
          default: w_res_addr = w_addr;
        endcase
      end
      B_RD: begin
        w_res_rd = (w_k != 3'd4);
        case (w_k)
          3'd1:    w_res_addr = w_addr + A_ROW + A_ONE;
          3'd2:    w_res_addr = w_addr + A_ROW;
          3'd3:    w_res_addr = w_addr + A_ROW - A_ONE;
          default: w_res_addr = w_addr;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      sti_rd   <= 1'b0;
      sti_addr <= '0;
      res_rd   <= 1'b0;
      res_wr   <= 1'b0;
      res_addr <= '0;
      res_do   <= '0;
    end else begin
      busy     <= w_busy;
      done     <= w_done;
      sti_rd   <= w_sti_rd;
      sti_addr <= w_sti_addr;
      res_rd   <= w_res_rd;
      res_wr   <= w_res_wr;
      res_addr <= w_res_addr;
      res_do   <= w_res_do;
    end
  end

  // Read data for read k arrives while r_k == k+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= 1'b0;
      r_ld_d <= 1'b0;
      r_word <= '0;
      r_min  <= '0;
      r_v    <= '0;
      r_last <= '0;
    end else begin
      r_ld_d <= (r_state == F_LOAD);
      r_word <= w_word;
      if (r_state == IDLE && start) r_mode <= mode;
      unique case (r_state)
        F_EDGE: begin
          r_word <= w_word << 1;
          r_last <= '0;
        end
        F_WR:   r_word <= w_word << 1;
        B_EDGE: r_last <= '0;
        F_RD: begin
          case (r_k)
            3'd1:    r_min  <= r_mode ? res_di : MAXV;
            3'd2:    r_min  <= f_min(r_min, res_di);
            3'd3:    r_last <= w_fres;
            default: ;
          endcase
        end
        B_RD: begin
          case (r_k)
            3'd1:    r_v    <= res_di;
            3'd2:    r_min  <= r_mode ? res_di : MAXV;
            3'd3:    r_min  <= f_min(r_min, res_di);
            3'd4:    r_last <= w_bres;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dt_param.sv
// tb_dt_param: random and directed images vs a brute-force distance model.
// Two instances: 8-bit words/8-bit results, 16-bit words/2-bit results.
module tb_dt_param;

  localparam int W = 16;
  localparam int H = 16;
  localparam int N = W*H;

  logic clk = 1'b0;
  logic reset, start, mode, fill;
  always #5 clk = ~clk;

  logic       a_busy, a_done, a_sti_rd, a_res_rd, a_res_wr;
  logic [4:0] a_sti_addr;
  logic [7:0] a_sti_di, a_res_addr, a_res_do, a_res_di;

  logic        b_busy, b_done, b_sti_rd, b_res_rd, b_res_wr;
  logic [3:0]  b_sti_addr;
  logic [15:0] b_sti_di;
  logic [7:0]  b_res_addr;
  logic [1:0]  b_res_do, b_res_di;

  dt_param #(.IMG_W(W), .IMG_H(H), .WORD_W(8), .DIST_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(a_busy), .done(a_done),
    .sti_rd(a_sti_rd), .sti_addr(a_sti_addr), .sti_di(a_sti_di),
    .res_rd(a_res_rd), .res_wr(a_res_wr), .res_addr(a_res_addr),
    .res_do(a_res_do), .res_di(a_res_di)
  );

  dt_param #(.IMG_W(W), .IMG_H(H), .WORD_W(16), .DIST_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(b_busy), .done(b_done),
    .sti_rd(b_sti_rd), .sti_addr(b_sti_addr), .sti_di(b_sti_di),
    .res_rd(b_res_rd), .res_wr(b_res_wr), .res_addr(b_res_addr),
    .res_do(b_res_do), .res_di(b_res_di)
  );

  bit         src [N];
  logic [7:0] mem_a [N];
  logic [1:0] mem_b [N];
  int         nd_a = 0, nd_b = 0, n_both = 0;
  int         n_chk = 0, n_fail = 0;

  function automatic logic [7:0] word_a(input logic [4:0] ad);
    logic [7:0] w;
    for (int j = 0; j < 8; j++) w[7-j] = src[int'(ad)*8 + j];
    return w;
  endfunction

  function automatic logic [15:0] word_b(input logic [3:0] ad);
    logic [15:0] w;
    for (int j = 0; j < 16; j++) w[15-j] = src[int'(ad)*16 + j];
    return w;
  endfunction

  always @(posedge clk) begin
    if (a_sti_rd) a_sti_di <= word_a(a_sti_addr);
    if (b_sti_rd) b_sti_di <= word_b(b_sti_addr);
    if (fill) begin
      for (int i = 0; i < N; i++) begin
        mem_a[i] <= 8'($urandom);
        mem_b[i] <= 2'($urandom);
      end
    end else begin
      if (a_res_wr) mem_a[a_res_addr] <= a_res_do;
      if (b_res_wr) mem_b[b_res_addr] <= b_res_do;
    end
    if (a_res_rd) a_res_di <= mem_a[a_res_addr];
    if (b_res_rd) b_res_di <= mem_b[b_res_addr];
    if ((a_res_rd && a_res_wr) || (b_res_rd && b_res_wr)) n_both++;
    if (a_done) nd_a++;
    if (b_done) nd_b++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Distance to the nearest zero pixel; the image frame counts as zero.
  function automatic int model(input int p, input bit m, input int maxv);
    int r, c, d, dr, dc, x;
    r = p / W;
    c = p % W;
    if (r == 0 || r == H-1 || c == 0 || c == W-1 || !src[p]) return 0;
    d = r;
    if (H-1-r < d) d = H-1-r;
    if (c < d) d = c;
    if (W-1-c < d) d = W-1-c;
    for (int q = 0; q < N; q++) begin
      if (!src[q]) begin
        dr = (q/W > r) ? q/W - r : r - q/W;
        dc = (q%W > c) ? q%W - c : c - q%W;
        x = m ? ((dr > dc) ? dr : dc) : dr + dc;
        if (x < d) d = x;
      end
    end
    return (d > maxv) ? maxv : d;
  endfunction

  task automatic run_xform(input bit m, input bit poke, input string tag);
    int ba, bb, cyc;
    ba = nd_a;
    bb = nd_b;
    cyc = 0;
    @(negedge clk) fill = 1'b1;
    @(negedge clk) fill = 1'b0;
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = 1'($urandom);
    while ((nd_a == ba || nd_b == bb) && cyc < 4000) begin
      if (poke && cyc == 200) begin
        start = 1'b1;
        mode = ~m;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_timeout"}, int'(cyc < 4000), 1);
    check({tag, "_cycles"}, int'(cyc <= 12*N), 1);
    repeat (5) @(negedge clk);
    check({tag, "_done_a"}, nd_a - ba, 1);
    check({tag, "_done_b"}, nd_b - bb, 1);
    check({tag, "_idle"}, int'(a_busy | b_busy), 0);
    for (int p = 0; p < N; p++) begin
      check($sformatf("%s_a_p%0d", tag, p), int'(mem_a[p]), model(p, m, 255));
      check($sformatf("%s_b_p%0d", tag, p), int'(mem_b[p]), model(p, m, 3));
    end
  endtask

  task automatic spot(input string tag, input bit useb,
                      input int r, input int c, input int v);
    int obs;
    obs = useb ? int'(mem_b[r*W+c]) : int'(mem_a[r*W+c]);
    check($sformatf("%s_%0d_%0d", tag, r, c), obs, v);
  endtask

  task automatic img_block();
    for (int p = 0; p < N; p++)
      src[p] = (p/W >= 5 && p/W <= 10 && p%W >= 5 && p%W <= 10);
  endtask

  initial begin
    int found, ba, bb, k;
    reset = 1'b1;
    start = 1'b0;
    mode  = 1'b1;
    fill  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(a_busy), 0);
    check("rst_done", int'(a_done), 0);
    check("rst_wr", int'(a_res_wr | b_res_wr), 0);
    check("rst_rd", int'(a_res_rd | a_sti_rd), 0);
    check("rst_addr", int'(a_res_addr) + int'(b_sti_addr), 0);
    check("rst_do", int'(a_res_do), 0);
    reset = 1'b0;

    for (int p = 0; p < N; p++) src[p] = 1'b0;
    run_xform(1'b1, 1'b0, "zero");

    img_block();
    run_xform(1'b1, 1'b0, "blk");
    for (int c = 5; c <= 10; c++) spot("blk", 1'b0, 5, c, 1);
    for (int c = 6; c <= 9; c++) spot("blk", 1'b0, 6, c, 2);
    spot("blk", 1'b0, 7, 7, 3);
    spot("blk", 1'b0, 8, 8, 3);
    spot("blk", 1'b0, 4, 4, 0);
    spot("blk", 1'b0, 11, 11, 0);

    for (int p = 0; p < N; p++) src[p] = 1'b1;
    src[8*W+8] = 1'b0;
    run_xform(1'b1, 1'b0, "hole8");
    spot("hole8", 1'b0, 7, 7, 1);
    spot("hole8", 1'b0, 6, 6, 2);
    spot("hole8", 1'b0, 0, 5, 0);
    run_xform(1'b0, 1'b0, "hole4");
    spot("hole4", 1'b0, 7, 7, 2);
    spot("hole4", 1'b0, 7, 8, 1);
    spot("hole4", 1'b0, 6, 6, 4);
    spot("hole4", 1'b0, 15, 3, 0);

    for (int p = 0; p < N; p++) src[p] = 1'b1;
    run_xform(1'b1, 1'b0, "sat");
    spot("sat", 1'b1, 1, 1, 1);
    spot("sat", 1'b1, 2, 2, 2);
    spot("sat", 1'b1, 8, 8, 3);
    spot("sat", 1'b0, 8, 8, 7);

    for (int t = 0; t < 4; t++) begin
      k = $urandom_range(4, 9);
      for (int p = 0; p < N; p++) src[p] = ($urandom_range(0, 9) < k);
      run_xform(1'($urandom), 1'b0, $sformatf("rnd%0d", t));
    end

    img_block();
    mode = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      @(negedge clk);
      if (a_res_wr && a_res_addr == 8'd99) found = 1;
    end
    check("rst_mid_hit", found, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_wr_a", int'(a_res_wr), 0);
    check("rst_mid_wr_b", int'(b_res_wr), 0);
    check("rst_mid_busy", int'(a_busy | b_busy), 0);
    @(negedge clk) reset = 1'b0;
    ba = nd_a;
    bb = nd_b;
    repeat (100) @(negedge clk);
    check("rst_mid_nodone", (nd_a - ba) + (nd_b - bb), 0);
    run_xform(1'b1, 1'b0, "rerun");
    spot("rerun", 1'b0, 7, 8, 3);

    k = $urandom_range(5, 8);
    for (int p = 0; p < N; p++) src[p] = ($urandom_range(0, 9) < k);
    run_xform(1'b1, 1'b1, "poke8");
    run_xform(1'b0, 1'b1, "poke4");

    check("rd_wr_excl", n_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
